// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: function codes, condition-code
// bit positions, FSM state encoding and a condition-code packing helper.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_XOR = 3'd3;
  localparam logic [2:0] ALU_MUL = 3'd4;

  localparam int CC_ZF = 0;
  localparam int CC_SF = 1;
  localparam int CC_OF = 2;
  localparam int CC_CF = 3;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  function automatic logic [3:0] pack_cc(input logic cf, input logic of,
                                         input logic sf, input logic zf);
    logic [3:0] cc;
    cc        = '0;
    cc[CC_CF] = cf;
    cc[CC_OF] = of;
    cc[CC_SF] = sf;
    cc[CC_ZF] = zf;
    return cc;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Decode-to-execute bundle: request side (operands, function, start) and
// result side (busy/done handshake, result, condition codes).
interface alu_seq_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [2:0]       alu_fun;
  logic [WIDTH-1:0] aluA;
  logic [WIDTH-1:0] aluB;
  logic             update_cc;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] valE;
  logic [3:0]       new_cc;
  logic             set_cc;
  logic             error;

  modport master (
    output start, alu_fun, aluA, aluB, update_cc,
    input  busy, done, valE, new_cc, set_cc, error
  );

  modport slave (
    input  start, alu_fun, aluA, aluB, update_cc,
    output busy, done, valE, new_cc, set_cc, error
  );
endinterface

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier: one step per clock over a 2*WIDTH accumulator,
// WIDTH steps per product.
module seq_multiplier #(
  parameter int WIDTH = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);
  localparam int CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     sum;

  // Upper half accumulates the multiplicand; lower half holds the remaining
  // multiplier bits and shifts out one bit per step.
  assign sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);

  // product is the accumulator after the step in progress, so it is final
  // in the same cycle that last is high.
  assign product = {sum, acc[WIDTH-1:1]};
  assign last    = busy && (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      busy  <= 1'b0;
      count <= '0;
      mcand <= '0;
      acc   <= '0;
    end else if (load && !busy) begin
      busy  <= 1'b1;
      count <= '0;
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
    end else if (busy) begin
      acc   <= product;
      count <= count + CNT_W'(1);
      if (last) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Execute-stage ALU: single-cycle add/sub/and/xor, multi-cycle unsigned
// multiply, registered result, condition codes and one-cycle done pulse.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic       clock,
  input  logic       reset,
  alu_seq_if.slave   bus
);
  localparam int MSB = WIDTH - 1;

  state_t           state;
  logic             busy_q;
  logic             done_q;
  logic             set_cc_q;
  logic             error_q;
  logic [WIDTH-1:0] val_q;
  logic [3:0]       cc_q;
  logic             upd_q;

  logic [WIDTH:0]     add_full;
  logic [WIDTH-1:0]   sub_res;
  logic [WIDTH-1:0]   simple_res;
  logic               simple_cf;
  logic               simple_of;
  logic [3:0]         simple_cc;

  logic               mul_load;
  logic               mul_busy;
  logic               mul_last;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH-1:0]   mul_lo;
  logic [3:0]         mul_cc;

  assign add_full = {1'b0, bus.aluB} + {1'b0, bus.aluA};
  assign sub_res  = bus.aluB - bus.aluA;

  always_comb begin
    simple_res = '0;
    simple_cf  = 1'b0;
    simple_of  = 1'b0;
    case (bus.alu_fun)
      ALU_ADD: begin
        simple_res = add_full[WIDTH-1:0];
        simple_cf  = add_full[WIDTH];
        simple_of  = (bus.aluA[MSB] == bus.aluB[MSB]) &&
                     (simple_res[MSB] != bus.aluA[MSB]);
      end
      ALU_SUB: begin
        simple_res = sub_res;
        simple_cf  = bus.aluA > bus.aluB;
        simple_of  = (bus.aluA[MSB] != bus.aluB[MSB]) &&
                     (simple_res[MSB] != bus.aluB[MSB]);
      end
      ALU_AND: simple_res = bus.aluA & bus.aluB;
      ALU_XOR: simple_res = bus.aluA ^ bus.aluB;
      default: simple_res = '0;
    endcase
    simple_cc = pack_cc(simple_cf, simple_of, simple_res[MSB], simple_res == '0);
  end

  assign mul_load = (state == S_IDLE) && bus.start && (bus.alu_fun == ALU_MUL);
  assign mul_lo   = mul_product[WIDTH-1:0];
  assign mul_cc   = pack_cc(mul_product[2*WIDTH-1:WIDTH] != '0,
                            mul_product[2*WIDTH-1:WIDTH] != '0,
                            mul_lo[MSB], mul_lo == '0);

  seq_multiplier #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clock   (clock),
    .reset   (reset),
    .load    (mul_load),
    .a       (bus.aluA),
    .b       (bus.aluB),
    .busy    (mul_busy),
    .product (mul_product),
    .last    (mul_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      set_cc_q <= 1'b0;
      error_q  <= 1'b0;
      val_q    <= '0;
      cc_q     <= '0;
      upd_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      set_cc_q <= 1'b0;
      error_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            upd_q <= bus.update_cc;
            if (bus.alu_fun < ALU_MUL) begin
              val_q    <= simple_res;
              cc_q     <= simple_cc;
              done_q   <= 1'b1;
              set_cc_q <= bus.update_cc;
            end else if (bus.alu_fun == ALU_MUL) begin
              busy_q <= 1'b1;
              state  <= S_MUL;
            end else begin
              val_q   <= '0;
              cc_q    <= '0;
              done_q  <= 1'b1;
              error_q <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (mul_busy && mul_last) begin
            val_q    <= mul_lo;
            cc_q     <= mul_cc;
            done_q   <= 1'b1;
            set_cc_q <= upd_q;
            busy_q   <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.set_cc = set_cc_q;
  assign bus.error  = error_q;
  assign bus.valE   = val_q;
  assign bus.new_cc = cc_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Execute-stage arithmetic unit for the sequential CPU. It takes operands and a function code from decode, computes `valE` and the 4-bit condition flags, and drives `new_cc`/`set_cc` straight into the condition-code register downstream. Add, sub, and, and xor complete in one cycle. Unsigned multiply uses a multi-cycle shift-add sequence behind a start/busy/done handshake.

## Interface
Parameters:
- `WIDTH`, default 64: operand and result width; must be ≥ 2.

Ports:
- `clock`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: request; accepted only when `busy`=0.
- `alu_fun`, in, 3: 0 ADD (B+A), 1 SUB (B−A), 2 AND, 3 XOR, 4 MUL (A×B, low half); 5–7 illegal.
- `aluA`, in, WIDTH: operand A.
- `aluB`, in, WIDTH: operand B.
- `update_cc`, in, 1: the instruction writes condition codes; captured with `start`.
- `busy`, out, 1: operation in progress; `start` is ignored while high.
- `done`, out, 1: one-cycle pulse when `valE`/`new_cc` are valid.
- `valE`, out, WIDTH: result; held until the next `done`.
- `new_cc`, out, 4: {CF, OF, SF, ZF} = bits [3:0]; held with `valE`.
- `set_cc`, out, 1: one-cycle pulse, equal to `done` AND captured `update_cc`.
- `error`, out, 1: pulses with `done` for an illegal `alu_fun`.

## Operation
States are IDLE and MUL. There is no separate DONE state: `done` is a registered pulse.
- IDLE with `start`=1:
  - Capture `alu_fun`, `aluA`, `aluB`, `update_cc`.
  - Codes 0–3: result and flags are registered at the same edge; `done` pulses; stay in IDLE.
  - Code 4: load the multiplier and multiplicand, clear the accumulator, set count=0, set `busy`; go to MUL.
  - Codes 5–7: `valE`=0, `new_cc`=0, `error`=1 and `done`=1 for one cycle, `set_cc`=0.
- MUL: one shift-add step per edge over a 2·WIDTH accumulator.
  - After WIDTH steps, register the low half to `valE`, pulse `done` (and `set_cc` if captured), clear `busy`, return to IDLE.
- Flag rules (R = WIDTH-bit result):
  - All ops: ZF = (R==0); SF = R[WIDTH−1].
  - ADD: CF = carry out of B+A; OF = (A[msb]==B[msb]) && (R[msb]!=A[msb]).
  - SUB: CF = borrow (A >u B); OF = (A[msb]!=B[msb]) && (R[msb]!=B[msb]).
  - AND/XOR: CF = OF = 0.
  - MUL: CF = OF = (high half of the product != 0).
- `start` while `busy` is dropped silently, with no queueing.

## Timing
- Reset: state IDLE; `busy`, `done`, `set_cc`, `error` = 0; `valE` = 0; `new_cc` = 0.
- Reset mid-MUL aborts the operation: no `done`, no `set_cc`.
- Simple ops: `start` sampled at edge k → `done`/`valE`/`new_cc` valid in the cycle after edge k (latency 1).
- MUL: `start` at edge k → `busy`=1 after edge k. Steps occur at edges k+1…k+WIDTH. `done`=1 and `busy`=0 after edge k+WIDTH (latency WIDTH).
- Back-to-back: `start` in the same cycle `done` is high (IDLE) is accepted. A simple op can therefore issue every cycle.
- `done`, `set_cc`, and `error` are exactly one cycle wide. `valE` and `new_cc` change only on a `done` edge.
- `reset` and `start` high together: reset wins.

## Structure
- Shared package `alu_pkg`:
  - `alu_fun` code constants (ALU_ADD…ALU_MUL).
  - CC bit indices (CC_ZF=0, CC_SF=1, CC_OF=2, CC_CF=3).
  - State encoding (S_IDLE, S_MUL).
- Sub-module `seq_multiplier`:
  - Interface: `clock`, `reset`, `load`, `a`, `b`, `busy`, `product[2·WIDTH−1:0]`, `last`.
  - Owns the counter and accumulator.
  - `alu_seq` keeps the FSM, the single-cycle ops, flags, and output registers.

## Test plan
All scenarios use WIDTH=64.
1. ADD A=1, B=0x7FFF_FFFF_FFFF_FFFF, `update_cc`=1 → next cycle `valE`=0x8000_0000_0000_0000, `new_cc`=4'b0110, `done`=`set_cc`=1 for 1 cycle.
2. SUB A=5, B=5 → `valE`=0, `new_cc`=4'b0001. Then SUB A=6, B=5 → `valE`=0xFFFF_FFFF_FFFF_FFFF, `new_cc`=4'b1010.
3. MUL A=0x10, B=0x20 → `busy` high for 64 cycles, `done` exactly 64 cycles after `start`, `valE`=0x200, `new_cc`=0. A `start` pulse at cycle 10 of the MUL has no effect.
4. MUL A=2^63, B=2 → `valE`=0, `new_cc`=4'b1101. Repeat with `update_cc`=0 → `done`=1, `set_cc` stays 0, `new_cc` identical.
5. Reset asserted after 30 MUL steps → next cycle `busy`=0 and all outputs 0. No `done` appears for the following 100 cycles. A new ADD then completes normally.
6. `alu_fun`=6 → `error`=`done`=1 for 1 cycle, `valE`=0, `set_cc`=0. Back-to-back XOR A=0xFF, B=0x0F in the `done` cycle → `valE`=0xF0 the next cycle.
